// File: rtl/stage_mem.sv
// stage_mem: memory-access pipeline stage.
// Loads and stores are done over a byte-serial, little-endian memory port,
// one byte per mem_req/mem_ready handshake. The stage holds the pipeline with
// stallreq until the access completes, then presents the write-back triple.
module stage_mem #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        aluop_i,
   input  logic [4:0]        reg_waddr_i,
   input  logic              we_i,
   input  logic [31:0]       reg_wdata_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       rt_data_i,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ready,
   output logic [4:0]        reg_waddr_o,
   output logic              we_o,
   output logic [31:0]       reg_wdata_o,
   output logic              stallreq,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata
);

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t      state_r;
   logic [1:0]  cnt_r;
   logic [31:0] buf_r;
   logic        mem_op_s;
   logic        store_op_s;
   logic [1:0]  last_idx_s;

   function automatic logic is_mem_op(input logic [7:0] op);
      case (op)
         EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP,
         EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

   function automatic logic is_store_op(input logic [7:0] op);
      case (op)
         EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

   // Index of the final byte of the access (size minus one).
   function automatic logic [1:0] last_byte_idx(input logic [7:0] op);
      case (op)
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2'd1;
         EXE_LW_OP, EXE_SW_OP:             return 2'd3;
         default:                          return 2'd0;
      endcase
   endfunction

   // Sign- or zero-extend the assembled load bytes according to the op.
   function automatic logic [31:0] load_ext(input logic [7:0] op, input logic [31:0] b);
      case (op)
         EXE_LB_OP:  return {{24{b[7]}}, b[7:0]};
         EXE_LBU_OP: return {24'd0, b[7:0]};
         EXE_LH_OP:  return {{16{b[15]}}, b[15:0]};
         EXE_LHU_OP: return {16'd0, b[15:0]};
         EXE_LW_OP:  return b;
         default:    return 32'd0;
      endcase
   endfunction

   assign mem_op_s   = is_mem_op(aluop_i);
   assign store_op_s = is_store_op(aluop_i);
   assign last_idx_s = last_byte_idx(aluop_i);

   // Write-back outputs and stall request, decoded from the current state.
   always_comb begin
      reg_waddr_o = 5'd0;
      we_o        = 1'b0;
      reg_wdata_o = 32'd0;
      stallreq    = 1'b0;
      if (rst) begin
         reg_waddr_o = 5'd0;
         we_o        = 1'b0;
         reg_wdata_o = 32'd0;
         stallreq    = 1'b0;
      end else if (!mem_op_s) begin
         reg_waddr_o = reg_waddr_i;
         we_o        = we_i;
         reg_wdata_o = reg_wdata_i;
         stallreq    = 1'b0;
      end else begin
         reg_waddr_o = reg_waddr_i;
         case (state_r)
            ST_DONE: begin
               stallreq = 1'b0;
               if (store_op_s) begin
                  we_o        = 1'b0;
                  reg_wdata_o = 32'd0;
               end else begin
                  we_o        = we_i;
                  reg_wdata_o = load_ext(aluop_i, buf_r);
               end
            end
            ST_IDLE, ST_ACCESS: begin
               stallreq    = 1'b1;
               we_o        = 1'b0;
               reg_wdata_o = 32'd0;
            end
            default: begin
               stallreq    = 1'b1;
               we_o        = 1'b0;
               reg_wdata_o = 32'd0;
            end
         endcase
      end
   end

   // Access sequencer: issues one byte request per handshake and collects load bytes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 2'd0;
         buf_r      <= 32'd0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr_o <= '0;
         mem_wdata  <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (mem_op_s) begin
                  state_r    <= ST_ACCESS;
                  cnt_r      <= 2'd0;
                  buf_r      <= 32'd0;
                  mem_req    <= 1'b1;
                  mem_we     <= store_op_s;
                  mem_addr_o <= mem_addr_i;
                  mem_wdata  <= rt_data_i[7:0];
               end else begin
                  mem_req <= 1'b0;
               end
            end
            ST_ACCESS: begin
               if (mem_req && mem_ready) begin
                  if (!store_op_s) begin
                     buf_r[{cnt_r, 3'b000} +: 8] <= mem_rdata;
                  end
                  if (cnt_r != last_idx_s) begin
                     cnt_r      <= cnt_r + 2'd1;
                     mem_addr_o <= mem_addr_o + ADDR_W'(1);
                     mem_wdata  <= rt_data_i[{cnt_r + 2'd1, 3'b000} +: 8];
                  end else begin
                     mem_req <= 1'b0;
                     state_r <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               mem_req <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               mem_req <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: self-checking bench for stage_mem.
// A transaction-level model expands each op into its expected per-cycle
// outputs (stall, byte requests with addresses/data, final write-back) and
// also plays the byte-serial memory with programmable wait cycles.
module tb_stage_mem;

   localparam logic [7:0] OP_LB  = 8'b1110_0000;
   localparam logic [7:0] OP_LH  = 8'b1110_0001;
   localparam logic [7:0] OP_LW  = 8'b1110_0011;
   localparam logic [7:0] OP_LBU = 8'b1110_0100;
   localparam logic [7:0] OP_LHU = 8'b1110_0101;
   localparam logic [7:0] OP_SB  = 8'b1110_1000;
   localparam logic [7:0] OP_SH  = 8'b1110_1001;
   localparam logic [7:0] OP_SW  = 8'b1110_1011;
   localparam logic [7:0] OP_ADD = 8'b0010_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [4:0]  reg_waddr_i;
   logic        we_i;
   logic [31:0] reg_wdata_i;
   logic [31:0] mem_addr_i;
   logic [31:0] rt_data_i;
   logic [7:0]  mem_rdata;
   logic        mem_ready;
   logic [4:0]  reg_waddr_o;
   logic        we_o;
   logic [31:0] reg_wdata_o;
   logic        stallreq;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr_o;
   logic [7:0]  mem_wdata;

   always #5 clk = ~clk;

   stage_mem #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg_waddr_i(reg_waddr_i),
      .we_i(we_i), .reg_wdata_i(reg_wdata_i), .mem_addr_i(mem_addr_i),
      .rt_data_i(rt_data_i), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .reg_waddr_o(reg_waddr_o), .we_o(we_o), .reg_wdata_o(reg_wdata_o),
      .stallreq(stallreq), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_o(mem_addr_o), .mem_wdata(mem_wdata)
   );

   typedef struct {
      string       name;
      logic        stall;
      logic        req;
      logic        chk_port;
      logic        mwe;
      logic [31:0] maddr;
      logic [7:0]  mwd;
      logic        chk_wb;
      logic        weo;
      logic [31:0] wdo;
      logic [4:0]  wao;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  mem_m [int unsigned];
   int          n_vec = 0;
   int          n_bad = 0;
   int          run_c = 0;
   int          last_run = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input string nm, input logic st, input logic rq,
                               input logic cp, input logic mw, input logic [31:0] ma,
                               input logic [7:0] md, input logic cw, input logic wo,
                               input logic [31:0] wd, input logic [4:0] wa);
      exp_t e;
      e.name = nm; e.stall = st; e.req = rq; e.chk_port = cp; e.mwe = mw;
      e.maddr = ma; e.mwd = md; e.chk_wb = cw; e.weo = wo; e.wdo = wd; e.wao = wa;
      return e;
   endfunction

   // Bytes per access; 0 means the op does not touch memory.
   function automatic int op_size(input logic [7:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         OP_LW, OP_SW:         return 4;
         default:              return 0;
      endcase
   endfunction

   function automatic logic [7:0] rd_mem(input logic [31:0] a);
      if (!mem_m.exists(a)) mem_m[a] = 8'($urandom);
      return mem_m[a];
   endfunction

   // Compare process: one expected record per clock, checked mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, "/stallreq"}, 32'(stallreq), 32'(e.stall));
            chk({e.name, "/mem_req"}, 32'(mem_req), 32'(e.req));
            chk({e.name, "/reg_waddr_o"}, 32'(reg_waddr_o), 32'(e.wao));
            if (e.chk_port) begin
               chk({e.name, "/mem_we"}, 32'(mem_we), 32'(e.mwe));
               chk({e.name, "/mem_addr_o"}, mem_addr_o, e.maddr);
               chk({e.name, "/mem_wdata"}, 32'(mem_wdata), 32'(e.mwd));
            end
            if (e.chk_wb) begin
               chk({e.name, "/we_o"}, 32'(we_o), 32'(e.weo));
               chk({e.name, "/reg_wdata_o"}, reg_wdata_o, e.wdo);
            end
         end
      end
   end

   // Length of the most recent contiguous stallreq burst.
   always @(negedge clk) begin
      if (stallreq === 1'b1) begin
         run_c = run_c + 1;
      end else begin
         if (run_c > 0) last_run = run_c;
         run_c = 0;
      end
   end

   task automatic cyc(input logic r, input logic [7:0] op, input logic [4:0] wa,
                      input logic we, input logic [31:0] wd, input logic [31:0] a,
                      input logic [31:0] rt, input logic rdy, input logic [7:0] rdat,
                      input exp_t e);
      @(posedge clk);
      #1;
      rst = r; aluop_i = op; reg_waddr_i = wa; we_i = we; reg_wdata_i = wd;
      mem_addr_i = a; rt_data_i = rt; mem_ready = rdy; mem_rdata = rdat;
      exp_q.push_back(e);
   endtask

   // One pipeline op from issue to the cycle the pipeline advances past it.
   // waits holds 2 bits of extra wait cycles per byte.
   task automatic run_op(input string nm, input logic [7:0] op, input logic [4:0] wa,
                         input logic we, input logic [31:0] wd, input logic [31:0] a,
                         input logic [31:0] rt, input logic [7:0] waits,
                         input logic use_lit, input logic [31:0] lit, input int exp_run);
      int          n;
      int          wk;
      logic        st;
      logic [7:0]  bk;
      logic [31:0] val;
      logic [31:0] res;
      n  = op_size(op);
      st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
      if (n == 0) begin
         cyc(1'b0, op, wa, we, wd, a, rt, 1'($urandom), 8'($urandom),
             mk(nm, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b1, we, wd, wa));
         return;
      end
      cyc(1'b0, op, wa, we, wd, a, rt, 1'($urandom), 8'($urandom),
          mk(nm, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 32'd0, wa));
      val = 32'd0;
      for (int k = 0; k < n; k++) begin
         wk = int'(waits[2*k +: 2]);
         bk = st ? rt[8*k +: 8] : rd_mem(a + 32'(k));
         for (int j = 0; j <= wk; j++) begin
            cyc(1'b0, op, wa, we, wd, a, rt, (j == wk),
                (j == wk) ? bk : 8'($urandom),
                mk(nm, 1'b1, 1'b1, 1'b1, st, a + 32'(k), rt[8*k +: 8],
                   1'b0, 1'b0, 32'd0, wa));
         end
         if (st) mem_m[a + 32'(k)] = bk;
         val = val | (32'(bk) << (8 * k));
      end
      case (op)
         OP_LB:   res = 32'($signed(val[7:0]));
         OP_LH:   res = 32'($signed(val[15:0]));
         OP_LBU:  res = 32'(val[7:0]);
         OP_LHU:  res = 32'(val[15:0]);
         OP_LW:   res = val;
         default: res = 32'd0;
      endcase
      if (use_lit) res = lit;
      cyc(1'b0, op, wa, we, wd, a, rt, 1'($urandom), 8'($urandom),
          mk(nm, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b1,
             st ? 1'b0 : we, st ? 32'd0 : res, wa));
      if (exp_run > 0) begin
         @(negedge clk);
         #1;
         chk({nm, "/stall_cycles"}, 32'(last_run), 32'(exp_run));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] op_tab [9];
      logic [7:0] op;
      logic [31:0] a;
      op_tab[0] = OP_LB; op_tab[1] = OP_LH; op_tab[2] = OP_LW; op_tab[3] = OP_LBU;
      op_tab[4] = OP_LHU; op_tab[5] = OP_SB; op_tab[6] = OP_SH; op_tab[7] = OP_SW;
      op_tab[8] = OP_ADD;

      rst = 1'b1; aluop_i = OP_LW; reg_waddr_i = 5'd9; we_i = 1'b1;
      reg_wdata_i = 32'hCAFE_F00D; mem_addr_i = 32'h40; rt_data_i = 32'h1111_2222;
      mem_ready = 1'b1; mem_rdata = 8'h5A;

      // Reset: combinational outputs forced to zero, port registers cleared.
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, OP_LW, 5'd9, 1'b1, 32'hCAFE_F00D, 32'h40, 32'h1111_2222, 1'b1, 8'h5A,
             mk("reset", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 32'd0, 5'd0));
      end

      run_op("add", OP_ADD, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 8'd0, 1'b1, 32'h1234, 0);

      mem_m[32'h100] = 8'h78; mem_m[32'h101] = 8'h56;
      mem_m[32'h102] = 8'h34; mem_m[32'h103] = 8'h12;
      run_op("lw_100", OP_LW, 5'd3, 1'b1, 32'h0, 32'h100, 32'h0, 8'd0, 1'b1, 32'h1234_5678, 5);

      mem_m[32'h7] = 8'h80;
      run_op("lb_7", OP_LB, 5'd4, 1'b1, 32'h0, 32'h7, 32'h0, 8'd0, 1'b1, 32'hFFFF_FF80, 2);
      run_op("lbu_7", OP_LBU, 5'd4, 1'b1, 32'h0, 32'h7, 32'h0, 8'd0, 1'b1, 32'h0000_0080, 2);
      mem_m[32'h10] = 8'h00; mem_m[32'h11] = 8'h80;
      run_op("lh_10", OP_LH, 5'd6, 1'b1, 32'h0, 32'h10, 32'h0, 8'd0, 1'b1, 32'hFFFF_8000, 3);

      run_op("sh_wrap", OP_SH, 5'd7, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'hAABB_CCDD, 8'd0,
             1'b0, 32'd0, 3);
      run_op("sw_wait", OP_SW, 5'd8, 1'b1, 32'h0, 32'h20, 32'hDEAD_BEEF, 8'b0000_1100,
             1'b0, 32'd0, 8);

      // Reset in the middle of a word load, after two bytes.
      cyc(1'b0, OP_LW, 5'd2, 1'b1, 32'h0, 32'h300, 32'h0403_0201, 1'b0, 8'h00,
          mk("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 32'd0, 5'd2));
      cyc(1'b0, OP_LW, 5'd2, 1'b1, 32'h0, 32'h300, 32'h0403_0201, 1'b1, 8'h11,
          mk("rst_mid", 1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 8'h01, 1'b0, 1'b0, 32'd0, 5'd2));
      cyc(1'b0, OP_LW, 5'd2, 1'b1, 32'h0, 32'h300, 32'h0403_0201, 1'b1, 8'h22,
          mk("rst_mid", 1'b1, 1'b1, 1'b1, 1'b0, 32'h301, 8'h02, 1'b0, 1'b0, 32'd0, 5'd2));
      cyc(1'b1, OP_LW, 5'd2, 1'b1, 32'h0, 32'h300, 32'h0403_0201, 1'b0, 8'h33,
          mk("rst_mid", 1'b0, 1'b1, 1'b1, 1'b0, 32'h302, 8'h03, 1'b1, 1'b0, 32'd0, 5'd0));
      cyc(1'b0, OP_ADD, 5'd12, 1'b1, 32'h55, 32'h300, 32'h0, 1'b1, 8'h44,
          mk("post_rst", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 8'd0, 1'b1, 1'b1, 32'h55, 5'd12));
      mem_m[32'h50] = 8'h7F;
      run_op("lb_after_rst", OP_LB, 5'd13, 1'b1, 32'h0, 32'h50, 32'h0, 8'd0, 1'b1,
             32'h0000_007F, 2);

      // Randomized ops, waits and addresses (including the wrap region).
      for (int t = 0; t < 300; t++) begin
         op = op_tab[$urandom_range(0, 8)];
         a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                          : $urandom;
         run_op("rand", op, 5'($urandom), 1'($urandom), $urandom, a, $urandom,
                8'($urandom), 1'b0, 32'd0, 0);
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
